// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset PC and word size.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES      = 4;

    // A fetch address is usable only when it lands on a word boundary.
    function automatic logic pc_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational program memory
// and fills a single registered slot towards decode with a valid/ready handshake.
// Execute may redirect the PC; misaligned targets and fetches past the end of
// program memory park the block in a sticky fault state until reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle after reset, no fetch; redirects still honoured
// RUN   | normal fetching, one instruction per cycle while decode accepts
// FAULT | terminal; slot empty, PC frozen, redirects ignored
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
    localparam logic [31:0] STEP        = 32'(INSTR_BYTES);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_instr_q, out_instr_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_pc_plus4_q, out_pc_plus4_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic         adv;
    logic         pc_out_of_range;
    logic         handshake;

    // Word index of the current PC compared against memory depth; a depth of
    // 2^30 or more can never be exceeded, which the 32-bit compare handles.
    assign pc_out_of_range = ({2'b00, pc_q[31:2]} >= MEM_WORDS_W);

    // A handshake is only credited when no redirect flushes the slot that cycle.
    assign handshake = out_valid_q && out_ready && !redirect_valid;

    // Next-state, slot update and advance decision.
    always_comb begin
        adv            = !out_valid_q || out_ready;
        state_d        = state_q;
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        fault_d        = fault_q;
        fault_pc_d     = fault_pc_q;
        fetch_count_d  = fetch_count_q;

        if (handshake) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end

        case (state_q)
            FAULT: begin
                out_valid_d = 1'b0;
            end
            default: begin
                // BOOT and RUN share the redirect rule; only RUN fetches.
                state_d = RUN;
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    if (!pc_aligned(redirect_pc)) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (state_q == RUN && adv) begin
                    if (pc_out_of_range) begin
                        state_d     = FAULT;
                        fault_d     = 1'b1;
                        fault_pc_d  = pc_q;
                        out_valid_d = 1'b0;
                    end else begin
                        out_instr_d    = imem_instr;
                        out_pc_d       = pc_q;
                        out_pc_plus4_d = pc_q + STEP;
                        out_valid_d    = 1'b1;
                        pc_d           = pc_q + STEP;
                    end
                end
            end
        endcase
    end

    // State, PC and slot registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_instr_q    <= 32'd0;
            out_pc_q       <= 32'd0;
            out_pc_plus4_q <= STEP;
            fault_q        <= 1'b0;
            fault_pc_q     <= 32'd0;
            fetch_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            fault_q        <= fault_d;
            fault_pc_q     <= fault_pc_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for stream/stall/redirect, a queue of expected
// accepted instructions, and hand sequences for faults and asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic        chk_slot;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[18];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Program memory: word n holds 0x1000_0000 + n.
    assign imem_instr = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000_0000 + {2'b00, pc[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " valid"},  {31'd0, out_valid}, 32'd0);
        chk({tag, " instr"},  out_instr, 32'd0);
        chk({tag, " pc"},     out_pc, 32'd0);
        chk({tag, " pc4"},    out_pc_plus4, 32'd4);
        chk({tag, " fault"},  {31'd0, fault}, 32'd0);
        chk({tag, " fpc"},    fault_pc, 32'd0);
        chk({tag, " count"},  fetch_count, 32'd0);
        chk({tag, " addr"},   imem_addr, 32'd0);
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    // Called after inputs settle in a cycle: a handshake at the coming edge
    // must deliver the next instruction the scoreboard expects.
    task automatic scoreboard_step();
        logic [31:0] e;
        if (out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_instr", out_instr, word_at(e));
            end
        end
    endtask

    task automatic set_row(input int i, input logic ready, input logic rv, input logic [31:0] rpc,
                           input logic ev, input logic cs, input logic [31:0] epc,
                           input logic [31:0] ein, input logic [31:0] ea, input logic [31:0] ec);
        tbl[i].ready = ready; tbl[i].rv = rv; tbl[i].rpc = rpc;
        tbl[i].e_valid = ev; tbl[i].chk_slot = cs; tbl[i].e_pc = epc;
        tbl[i].e_instr = ein; tbl[i].e_addr = ea; tbl[i].e_cnt = ec;
    endtask

    initial begin
        int cyc;
        bit found;

        // Row = inputs for the cycle, outputs observed in that cycle (before its edge).
        set_row(0,  1, 0, 0,     0, 1, 32'h00, 32'h0,      32'h00, 0);
        set_row(1,  1, 0, 0,     0, 1, 32'h00, 32'h0,      32'h00, 0);
        set_row(2,  1, 0, 0,     1, 1, 32'h00, 32'h1000_0000, 32'h04, 0);
        set_row(3,  1, 0, 0,     1, 1, 32'h04, 32'h1000_0001, 32'h08, 1);
        set_row(4,  0, 0, 0,     1, 1, 32'h08, 32'h1000_0002, 32'h0C, 2);
        set_row(5,  0, 0, 0,     1, 1, 32'h08, 32'h1000_0002, 32'h0C, 2);
        set_row(6,  0, 0, 0,     1, 1, 32'h08, 32'h1000_0002, 32'h0C, 2);
        set_row(7,  1, 0, 0,     1, 1, 32'h08, 32'h1000_0002, 32'h0C, 2);
        set_row(8,  1, 0, 0,     1, 1, 32'h0C, 32'h1000_0003, 32'h10, 3);
        set_row(9,  1, 0, 0,     1, 1, 32'h10, 32'h1000_0004, 32'h14, 4);
        set_row(10, 0, 1, 32'h40, 1, 1, 32'h14, 32'h1000_0005, 32'h18, 5);
        set_row(11, 1, 0, 0,     0, 0, 32'h00, 32'h0,      32'h40, 5);
        set_row(12, 1, 0, 0,     1, 1, 32'h40, 32'h1000_0010, 32'h44, 5);
        set_row(13, 1, 0, 0,     1, 1, 32'h44, 32'h1000_0011, 32'h48, 6);
        set_row(14, 1, 0, 0,     1, 1, 32'h48, 32'h1000_0012, 32'h4C, 7);
        set_row(15, 1, 0, 0,     1, 1, 32'h4C, 32'h1000_0013, 32'h50, 8);
        set_row(16, 1, 0, 0,     1, 1, 32'h50, 32'h1000_0014, 32'h54, 9);
        set_row(17, 1, 0, 0,     1, 1, 32'h54, 32'h1000_0015, 32'h58, 10);

        rst = 1'b1;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        push_stream(32'h0, 32);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            out_ready      = tbl[i].ready;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            #1;
            chk($sformatf("t%0d valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("t%0d addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("t%0d count", i), fetch_count, tbl[i].e_cnt);
            if (tbl[i].chk_slot) begin
                chk($sformatf("t%0d pc", i), out_pc, tbl[i].e_pc);
                chk($sformatf("t%0d instr", i), out_instr, tbl[i].e_instr);
                chk($sformatf("t%0d pc4", i), out_pc_plus4,
                    (i < 2) ? 32'd4 : tbl[i].e_pc + 32'd4);
            end
            scoreboard_step();
            if (tbl[i].rv) push_stream(tbl[i].rpc, 32);
        end

        // Misaligned redirect: sticky fault, later aligned redirect ignored.
        @(negedge clk);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
        #1;
        scoreboard_step();
        @(negedge clk);
        redirect_pc = 32'h0;
        #1;
        chk("mis fault", {31'd0, fault}, 32'd1);
        chk("mis fpc", fault_pc, 32'h42);
        chk("mis valid", {31'd0, out_valid}, 32'd0);
        chk("mis count", fetch_count, 32'd11);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("ign fault", {31'd0, fault}, 32'd1);
        chk("ign fpc", fault_pc, 32'h42);
        chk("ign valid", {31'd0, out_valid}, 32'd0);
        chk("ign addr", imem_addr, 32'h5C);

        // Asynchronous reset while in FAULT, away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_fault");
        push_stream(32'h0, 256);

        // Restart and stream to the last legal word, then off the end.
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 300) begin
            @(negedge clk);
            if (cyc == 0) rst = 1'b0;
            out_ready = 1'b1;
            #1;
            if (cyc == 1) chk("rs first_gap", {31'd0, out_valid}, 32'd0);
            if (cyc == 2) begin
                chk("rs first_valid", {31'd0, out_valid}, 32'd1);
                chk("rs first_pc", out_pc, 32'h0);
            end
            if (out_valid && out_pc == 32'h3FC) begin
                found = 1'b1;
                chk("end instr", out_instr, 32'h1000_00FF);
                chk("end count", fetch_count, 32'd255);
                chk("end addr", imem_addr, 32'h400);
            end
            scoreboard_step();
            cyc++;
        end
        if (!found) chk("end timeout", out_pc, 32'h3FC);
        @(negedge clk);
        #1;
        chk("range fault", {31'd0, fault}, 32'd1);
        chk("range fpc", fault_pc, 32'h400);
        chk("range valid", {31'd0, out_valid}, 32'd0);
        chk("range count", fetch_count, 32'd256);

        // Reset mid-stream.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_stream(32'h0, 32);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            scoreboard_step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        push_stream(32'h0, 32);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            #1;
            if (k == 2) begin
                chk("mid first_valid", {31'd0, out_valid}, 32'd1);
                chk("mid first_pc", out_pc, 32'h0);
            end
            scoreboard_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
